expr_vector_sequencer: RTL and testbench

Run controller for the combinational expression datapaths in the vloghammer regression set. It accepts operand vectors over a valid/ready stream and drives them onto the datapath's packed `a`/`b` operand buses. After a fixed settle time it captures the 90-bit `y` result and returns it over a second valid/ready stream. It also folds every captured result into a 32-bit MISR signature, so a whole run can be compared against a golden value.

---
 rtl/expr_vector_sequencer.sv | 121 ++++++++++++
 tb/tb_expr_vector_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_vector_sequencer.sv
// Run controller for combinational expression datapaths: streams operand vectors
// onto dut_a/dut_b, captures dut_y after SETTLE cycles and folds it into a MISR.
module expr_vector_sequencer #(
  parameter int unsigned SETTLE = 1,
  parameter logic [31:0] POLY   = 32'h04C11DB7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] vec_count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [29:0] in_a,
  input  logic [29:0] in_b,
  output logic [29:0] dut_a,
  output logic [29:0] dut_b,
  input  logic [89:0] dut_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [89:0] out_y,
  output logic [15:0] out_idx,
  output logic [31:0] sig,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_OUT, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [15:0] idx;
  logic [15:0] count;
  logic        run_clr, load_en, cnt_dec, cap_en, out_acc;

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [89:0] y);
    logic [31:0] f;
    f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Handshake outputs decode from state alone; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    run_clr   = 1'b0;
    load_en   = 1'b0;
    cnt_dec   = 1'b0;
    cap_en    = 1'b0;
    out_acc   = 1'b0;
    in_ready  = (state == S_LOAD);
    out_valid = (state == S_OUT);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          run_clr   = 1'b1;
          state_nxt = (vec_count == 16'd0) ? S_DONE : S_LOAD;
        end
        S_LOAD: if (in_valid) begin
          load_en   = 1'b1;
          state_nxt = S_WAIT;
        end
        S_WAIT: if (cnt == 4'd0) begin
          cap_en    = 1'b1;
          state_nxt = S_OUT;
        end else begin
          cnt_dec   = 1'b1;
        end
        S_OUT: if (out_ready) begin
          out_acc   = 1'b1;
          state_nxt = (idx + 16'd1 == count) ? S_DONE : S_LOAD;
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      idx     <= 16'd0;
      count   <= 16'd0;
      dut_a   <= 30'd0;
      dut_b   <= 30'd0;
      out_y   <= 90'd0;
      out_idx <= 16'd0;
      sig     <= 32'd0;
    end else begin
      if (run_clr) begin
        sig   <= 32'd0;
        idx   <= 16'd0;
        count <= vec_count;
      end
      if (load_en) begin
        dut_a <= in_a;
        dut_b <= in_b;
        cnt   <= CNT_INIT;
      end else if (cnt_dec) begin
        cnt   <= cnt - 4'd1;
      end
      if (cap_en) begin
        out_y   <= dut_y;
        out_idx <= idx;
        sig     <= misr_step(sig, dut_y);
      end
      if (out_acc) idx <= idx + 16'd1;
    end
  end

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Bench for expr_vector_sequencer: transaction-level reference model checked every
// cycle on the SETTLE=1 instance, plus a loopback run on a SETTLE=4 instance.
module tb_expr_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, in_valid, out_ready;
  logic [15:0] vec_count;
  logic [29:0] in_a, in_b, dut_a, dut_b;
  logic [89:0] dut_y, out_y;
  logic        in_ready, out_valid, busy, done;
  logic [15:0] out_idx;
  logic [31:0] sig;
  logic        ymode;
  logic [89:0] y_const;

  logic        q_start, q_abort, q_in_valid, q_out_ready;
  logic [15:0] q_vec_count;
  logic [29:0] q_in_a, q_in_b, q_dut_a, q_dut_b;
  logic [89:0] q_dut_y, q_out_y;
  logic        q_in_ready, q_out_valid, q_busy, q_done;
  logic [15:0] q_out_idx;
  logic [31:0] q_sig;

  assign dut_y   = ymode ? {dut_a ^ dut_b, dut_b, dut_a} : y_const;
  assign q_dut_y = {30'b0, q_dut_a, q_dut_b};

  expr_vector_sequencer #(.SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_count(vec_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_idx(out_idx),
    .sig(sig), .busy(busy), .done(done));

  expr_vector_sequencer #(.SETTLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(q_start), .abort(q_abort), .vec_count(q_vec_count),
    .in_valid(q_in_valid), .in_ready(q_in_ready), .in_a(q_in_a), .in_b(q_in_b),
    .dut_a(q_dut_a), .dut_b(q_dut_b), .dut_y(q_dut_y),
    .out_valid(q_out_valid), .out_ready(q_out_ready), .out_y(q_out_y), .out_idx(q_out_idx),
    .sig(q_sig), .busy(q_busy), .done(q_done));

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [89:0] act, input logic [89:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [89:0] y);
    logic [31:0] f;
    f = 32'h0;
    for (int w = 0; w < 3; w++) f ^= 32'(y >> (32 * w));
    return (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [89:0] ref_y(input logic [29:0] a, input logic [29:0] b);
    return ymode ? {a ^ b, b, a} : y_const;
  endfunction

  // Reference model: tracks pending work as transactions and cycle deadlines.
  int          cyc = 0;
  int          cap_cyc = 0;
  int          done_cyc = -1;
  bit          m_want_in = 0, pend = 0;
  bit          exp_ov, exp_done, exp_busy;
  logic [89:0] pend_y;
  logic [29:0] pend_a, pend_b;
  logic [15:0] m_idx = 0, m_count = 0;
  logic [31:0] m_sig = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_want_in = 0; pend = 0; done_cyc = -1; m_sig = 0; m_idx = 0; m_count = 0;
      chk("reset_flags", {busy, done, in_ready, out_valid}, 4'b0);
      chk("reset_sig", sig, 32'h0);
    end else begin
      exp_done = (cyc == done_cyc);
      exp_ov   = pend && (cyc >= cap_cyc);
      exp_busy = m_want_in || pend || exp_done;
      if (pend && cyc == cap_cyc) m_sig = ref_misr(m_sig, pend_y);
      chk("m_in_ready", in_ready, m_want_in);
      chk("m_out_valid", out_valid, exp_ov);
      chk("m_busy", busy, exp_busy);
      chk("m_done", done, exp_done);
      chk("m_sig", sig, m_sig);
      if (exp_ov) begin
        chk("m_out_y", out_y, pend_y);
        chk("m_out_idx", out_idx, m_idx);
      end
      if (pend) chk("m_dut_ab", {dut_a, dut_b}, {pend_a, pend_b});
      if (exp_busy && abort) begin
        m_want_in = 0; pend = 0; done_cyc = -1;
      end else if (!exp_busy && start) begin
        m_sig = 0; m_idx = 0; m_count = vec_count;
        if (vec_count == 16'd0) done_cyc = cyc + 1;
        else                    m_want_in = 1;
      end else if (m_want_in && in_valid) begin
        m_want_in = 0; pend = 1;
        pend_a = in_a; pend_b = in_b; pend_y = ref_y(in_a, in_b);
        cap_cyc = cyc + 1 + 1;
      end else if (exp_ov && out_ready) begin
        pend = 0;
        m_idx = m_idx + 16'd1;
        if (m_idx == m_count) done_cyc = cyc + 1;
        else                  m_want_in = 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [29:0] ta, tb;
    logic [31:0] exp_sig;
    rst_n = 0; start = 0; abort = 0; in_valid = 0; out_ready = 0; vec_count = 0;
    in_a = 0; in_b = 0; ymode = 0; y_const = 0;
    q_start = 0; q_abort = 0; q_in_valid = 0; q_out_ready = 0; q_vec_count = 0;
    q_in_a = 0; q_in_b = 0;
    repeat (3) tick;
    rst_n = 1;
    tick;
    chk("idle_busy", busy, 1'b0);
    chk("idle_in_ready", in_ready, 1'b0);

    // Single vector, y tied to 1
    y_const = 90'h1;
    start = 1; vec_count = 16'd1;
    tick;
    start = 0; in_valid = 1; in_a = 30'h15; in_b = 30'h2a;
    chk("sv_in_ready", in_ready, 1'b1);
    tick;
    in_valid = 0;
    chk("sv_no_early_valid", out_valid, 1'b0);
    out_ready = 1;
    tick;
    chk("sv_out_valid", out_valid, 1'b1);
    chk("sv_out_idx", out_idx, 16'd0);
    chk("sv_sig", sig, 32'h1);
    tick;
    chk("sv_done", done, 1'b1);
    out_ready = 0;
    tick;
    chk("sv_done_once", done, 1'b0);
    chk("sv_idle", busy, 1'b0);

    // Two vectors y=1 then 0, output stalled five cycles
    start = 1; vec_count = 16'd2;
    tick;
    start = 0; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    y_const = 90'h0;
    repeat (5) begin
      tick;
      chk("stall_out_y", out_y, 90'h1);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1;
    tick;
    out_ready = 0; in_valid = 1;
    tick;
    in_valid = 0;
    tick;
    chk("two_sig", sig, 32'h2);
    chk("two_idx", out_idx, 16'd1);
    out_ready = 1;
    tick;
    out_ready = 0;
    chk("two_done", done, 1'b1);
    tick;

    // Zero-length run
    start = 1; vec_count = 16'd0;
    tick;
    start = 0;
    chk("zero_done", done, 1'b1);
    chk("zero_sig", sig, 32'h0);
    chk("zero_in_ready", in_ready, 1'b0);
    tick;
    chk("zero_idle", {busy, done}, 2'b00);

    // Abort in OUT with a simultaneous output handshake
    ymode = 1; ta = 30'h1234567; tb = 30'h0abcdef;
    exp_sig = ref_misr(32'h0, {ta ^ tb, tb, ta});
    start = 1; vec_count = 16'd3;
    tick;
    start = 0; in_valid = 1; in_a = ta; in_b = tb;
    tick;
    in_valid = 0;
    tick;
    out_ready = 1; abort = 1;
    tick;
    abort = 0; out_ready = 0;
    chk("abort_flags", {busy, done, out_valid, in_ready}, 4'b0);
    chk("abort_sig", sig, exp_sig);
    tick;
    chk("abort_no_done", done, 1'b0);
    start = 1; vec_count = 16'd2;
    tick;
    start = 0;
    chk("restart_sig", sig, 32'h0);
    abort = 1;
    tick;
    abort = 0;

    // Asynchronous reset while waiting for the datapath
    start = 1; vec_count = 16'd1;
    tick;
    start = 0; in_valid = 1; in_a = 30'h3ffffff; in_b = 30'h1;
    tick;
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_ab", {dut_a, dut_b}, 60'h0);
    chk("arst_y", out_y, 90'h0);
    chk("arst_misc", {sig, out_idx, busy, done, in_ready, out_valid}, 52'h0);
    tick;
    tick;
    rst_n = 1;
    tick;
    chk("arst_release", {busy, in_ready}, 2'b00);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      vec_count = 16'($urandom_range(0, 5));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = 30'($urandom);
      in_b      = 30'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      abort     = ($urandom_range(0, 49) == 0);
      tick;
    end
    start = 0; in_valid = 0; out_ready = 0; abort = 1;
    tick;
    abort = 0;
    tick;

    // SETTLE=4 loopback, both streams always ready
    begin : s4_test
      logic [29:0] qa [4];
      logic [29:0] qb [4];
      logic [31:0] qsig;
      int          kin, kout, last;
      bit          hs_in, hs_out, got_done;
      kin = 0; kout = 0; last = -1; qsig = 0; got_done = 0;
      for (int k = 0; k < 4; k++) begin
        qa[k] = 30'($urandom);
        qb[k] = 30'($urandom);
      end
      q_start = 1; q_vec_count = 16'd4;
      tick;
      q_start = 0; q_vec_count = 16'd9; q_in_valid = 1; q_out_ready = 1;
      for (int c = 0; c < 60 && !got_done; c++) begin
        q_in_a = qa[kin[1:0]];
        q_in_b = qb[kin[1:0]];
        hs_in  = q_in_ready;
        hs_out = q_out_valid;
        if (q_out_valid) begin
          chk("lb_out_y", q_out_y, {30'b0, qa[kout[1:0]], qb[kout[1:0]]});
          chk("lb_out_idx", q_out_idx, 16'(kout));
          if (last >= 0) chk("lb_period", 32'(c - last), 32'd6);
          last = c;
          qsig = ref_misr(qsig, {30'b0, qa[kout[1:0]], qb[kout[1:0]]});
          chk("lb_sig", q_sig, qsig);
        end
        if (q_done) begin
          got_done = 1;
          chk("lb_count", 32'(kout), 32'd4);
        end
        tick;
        if (hs_in) kin++;
        if (hs_out) kout++;
      end
      chk("lb_done_seen", got_done, 1'b1);
      q_in_valid = 0; q_out_ready = 0;
      tick;
      chk("lb_idle", q_busy, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
